// File: rtl/wb_pkg.sv
// ============================================================================
// Module : wb_pkg
// Brief  : Shared types and helpers for the writeback stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    typedef enum logic [0:0] {
        WB_IDLE     = 1'b0,
        WB_WAIT_MEM = 1'b1
    } wb_state_t;

    // Select width for an N-source mux; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_src_mux.sv
// ============================================================================
// Module : wb_src_mux
// Brief  : Combinational NSRC:1 source select; out-of-range select yields zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_src_mux
    import wb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NSRC   = 4,
    parameter int SEL_W  = sel_width(NSRC)
) (
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      data
);

    always_comb begin
        data = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SEL_W'(i)) begin
                data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// Module : writeback_unit
// Brief  : Register-file writeback with multi-cycle data-memory stall.
//          Optional WB_TIMEOUT_EN adds a wait-cycle abort with sticky wb_err.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module writeback_unit
    import wb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NSRC    = 4,
    parameter int MEM_IDX = 1,
    parameter int REG_AW  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wb_valid,
    input  logic [sel_width(NSRC)-1:0]  wb_sel,
    input  logic [REG_AW-1:0]           wb_dest,
    input  logic                        wb_wren,
    input  logic [NSRC*DATA_W-1:0]      src_data,
    input  logic                        mem_busywait,
    output logic                        wb_ready,
    output logic                        stall,
    output logic                        reg_write_en,
    output logic [REG_AW-1:0]           reg_write_addr,
    output logic [DATA_W-1:0]           reg_write_data,
    output logic                        wb_err
);

    localparam int SEL_W = sel_width(NSRC);

    wb_state_t          r_state, w_state_nxt;
    logic               r_en, w_en_nxt;
    logic [REG_AW-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]  r_data, w_data_nxt;
    logic [REG_AW-1:0]  r_dest, w_dest_nxt;
    logic               r_wren, w_wren_nxt;
    logic [DATA_W-1:0]  w_mux_data;
    logic               w_idle, w_sel_mem, w_accept;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_err, w_err_nxt;
`endif

    wb_src_mux #(
        .DATA_W (DATA_W),
        .NSRC   (NSRC),
        .SEL_W  (SEL_W)
    ) u_src_mux (
        .src_data (src_data),
        .sel      (wb_sel),
        .data     (w_mux_data)
    );

    // Gating with rst_n keeps ready/stall low while reset is held.
    assign w_idle    = (r_state == WB_IDLE);
    assign w_sel_mem = (wb_sel == SEL_W'(MEM_IDX));
    assign wb_ready  = rst_n & w_idle;
    assign w_accept  = wb_valid & wb_ready;
    assign stall     = rst_n & (~w_idle | (wb_valid & w_sel_mem));

    always_comb begin
        w_state_nxt = r_state;
        w_en_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_dest_nxt  = r_dest;
        w_wren_nxt  = r_wren;
`ifdef WB_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
`endif
        case (r_state)
            WB_IDLE: begin
                if (w_accept) begin
                    if (w_sel_mem) begin
                        w_dest_nxt  = wb_dest;
                        w_wren_nxt  = wb_wren;
                        w_state_nxt = WB_WAIT_MEM;
`ifdef WB_TIMEOUT_EN
                        w_cnt_nxt   = '0;
`endif
                    end else begin
                        w_en_nxt   = wb_wren;
                        w_addr_nxt = wb_dest;
                        w_data_nxt = w_mux_data;
                    end
                end
            end
            WB_WAIT_MEM: begin
                if (!mem_busywait) begin
                    w_en_nxt    = r_wren;
                    w_addr_nxt  = r_dest;
                    w_data_nxt  = src_data[MEM_IDX*DATA_W +: DATA_W];
                    w_state_nxt = WB_IDLE;
                end
`ifdef WB_TIMEOUT_EN
                // This busy cycle is the TIMEOUT-th one: abort without writing.
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = WB_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
`endif
            end
            default: w_state_nxt = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WB_IDLE;
            r_en    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_dest  <= '0;
            r_wren  <= 1'b0;
`ifdef WB_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_en    <= w_en_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_dest  <= w_dest_nxt;
            r_wren  <= w_wren_nxt;
`ifdef WB_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign reg_write_en   = r_en;
    assign reg_write_addr = r_addr;
    assign reg_write_data = r_data;
`ifdef WB_TIMEOUT_EN
    assign wb_err = r_err;
`else
    assign wb_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// Module : tb_writeback_unit
// Brief  : Directed self-checking bench for writeback_unit (NSRC=5, TIMEOUT=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_writeback_unit;

    localparam int DATA_W  = 8;
    localparam int NSRC    = 5;
    localparam int MEM_IDX = 1;
    localparam int REG_AW  = 3;
    localparam int TIMEOUT = 4;
    localparam int SEL_W   = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   wb_valid;
    logic [SEL_W-1:0]       wb_sel;
    logic [REG_AW-1:0]      wb_dest;
    logic                   wb_wren;
    logic [NSRC*DATA_W-1:0] src_data;
    logic                   mem_busywait;
    logic                   wb_ready;
    logic                   stall;
    logic                   reg_write_en;
    logic [REG_AW-1:0]      reg_write_addr;
    logic [DATA_W-1:0]      reg_write_data;
    logic                   wb_err;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt;
    int en_cnt;

    always #5 clk = ~clk;

    writeback_unit #(
        .DATA_W  (DATA_W),
        .NSRC    (NSRC),
        .MEM_IDX (MEM_IDX),
        .REG_AW  (REG_AW),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_valid       (wb_valid),
        .wb_sel         (wb_sel),
        .wb_dest        (wb_dest),
        .wb_wren        (wb_wren),
        .src_data       (src_data),
        .mem_busywait   (mem_busywait),
        .wb_ready       (wb_ready),
        .stall          (stall),
        .reg_write_en   (reg_write_en),
        .reg_write_addr (reg_write_addr),
        .reg_write_data (reg_write_data),
        .wb_err         (wb_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int sel, input int dest, input logic wren);
        wb_valid = v;
        wb_sel   = SEL_W'(sel);
        wb_dest  = REG_AW'(dest);
        wb_wren  = wren;
    endtask

    initial begin
        rst_n        = 1'b0;
        drive(1'b1, MEM_IDX, 0, 1'b1);
        src_data     = '0;
        mem_busywait = 1'b0;
        #1;
        check_eq("rst_ready", wb_ready, 0);
        check_eq("rst_stall", stall, 0);
        check_eq("rst_en", reg_write_en, 0);
        check_eq("rst_addr", reg_write_addr, 0);
        check_eq("rst_data", reg_write_data, 0);
        check_eq("rst_err", wb_err, 0);
        drive(1'b0, 0, 0, 1'b0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", wb_ready, 1);
        step();

        // 1: single ALU write
        src_data[0*8 +: 8] = 8'h5A;
        drive(1'b1, 0, 3, 1'b1);
        #1;
        check_eq("t1_stall_req", stall, 0);
        step();
        drive(1'b0, 0, 0, 1'b0);
        check_eq("t1_en", reg_write_en, 1);
        check_eq("t1_addr", reg_write_addr, 3);
        check_eq("t1_data", reg_write_data, 8'h5A);
        check_eq("t1_stall", stall, 0);
        step();
        check_eq("t1_en_off", reg_write_en, 0);
        check_eq("t1_data_hold", reg_write_data, 8'h5A);

        // 2: memory write, busy 3 cycles; valid in WAIT_MEM must be ignored
        src_data[1*8 +: 8] = 8'hC3;
        stall_cnt = 0;
        en_cnt    = 0;
        for (int k = 0; k < 6; k++) begin
            mem_busywait = (k < 3);
            if (k == 0)      drive(1'b1, MEM_IDX, 6, 1'b1);
            else if (k <= 2) drive(1'b1, 0, 2, 1'b1);
            else             drive(1'b0, 0, 0, 1'b0);
            #1;
            if (stall) stall_cnt++;
            if (k == 1) check_eq("t2_ready_wait", wb_ready, 0);
            if (reg_write_en) begin
                en_cnt++;
                check_eq("t2_addr", reg_write_addr, 6);
                check_eq("t2_data", reg_write_data, 8'hC3);
            end
            step();
        end
        check_eq("t2_stall_cycles", stall_cnt, 4);
        check_eq("t2_en_pulses", en_cnt, 1);
        check_eq("t2_ready_end", wb_ready, 1);

        // 3: back-to-back ALU writes on sel 0,2,3
        src_data[0*8 +: 8] = 8'h11;
        src_data[2*8 +: 8] = 8'h22;
        src_data[3*8 +: 8] = 8'h33;
        drive(1'b1, 0, 1, 1'b1);
        step();
        check_eq("t3_en0", reg_write_en, 1);
        check_eq("t3_data0", reg_write_data, 8'h11);
        drive(1'b1, 2, 2, 1'b1);
        step();
        check_eq("t3_en1", reg_write_en, 1);
        check_eq("t3_data1", reg_write_data, 8'h22);
        check_eq("t3_addr1", reg_write_addr, 2);
        drive(1'b1, 3, 4, 1'b1);
        step();
        check_eq("t3_en2", reg_write_en, 1);
        check_eq("t3_data2", reg_write_data, 8'h33);
        check_eq("t3_addr2", reg_write_addr, 4);
        drive(1'b0, 0, 0, 1'b0);
        step();
        check_eq("t3_en_off", reg_write_en, 0);

        // 4: reset during WAIT_MEM
        mem_busywait = 1'b1;
        drive(1'b1, MEM_IDX, 5, 1'b1);
        step();
        drive(1'b0, 0, 0, 1'b0);
        check_eq("t4_stall_wait", stall, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t4_rst_en", reg_write_en, 0);
        check_eq("t4_rst_data", reg_write_data, 0);
        check_eq("t4_rst_stall", stall, 0);
        check_eq("t4_rst_ready", wb_ready, 0);
        mem_busywait = 1'b0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("t4_ready_after", wb_ready, 1);
        step();
        check_eq("t4_no_write", reg_write_en, 0);
        check_eq("t4_addr_clear", reg_write_addr, 0);

        // 5: out-of-range select writes zero; WREN=0 memory request
        src_data = 40'h5544332211;
        drive(1'b1, 4, 1, 1'b1);
        step();
        check_eq("t5_data_sel4", reg_write_data, 8'h55);
        drive(1'b1, 5, 7, 1'b1);
        step();
        check_eq("t5_oor_en", reg_write_en, 1);
        check_eq("t5_oor_addr", reg_write_addr, 7);
        check_eq("t5_oor_data", reg_write_data, 8'h00);
        stall_cnt = 0;
        en_cnt    = 0;
        for (int k = 0; k < 4; k++) begin
            mem_busywait = 1'b0;
            if (k == 0) drive(1'b1, MEM_IDX, 2, 1'b0);
            else        drive(1'b0, 0, 0, 1'b0);
            #1;
            if (stall) stall_cnt++;
            if (k > 0 && reg_write_en) en_cnt++;
            step();
        end
        check_eq("t5_nowren_stall", stall_cnt, 2);
        check_eq("t5_nowren_en", en_cnt, 0);

`ifdef WB_TIMEOUT_EN
        // 6: timeout abort after TIMEOUT busy wait cycles
        stall_cnt = 0;
        en_cnt    = 0;
        for (int k = 0; k < 8; k++) begin
            mem_busywait = 1'b1;
            if (k == 0) drive(1'b1, MEM_IDX, 3, 1'b1);
            else        drive(1'b0, 0, 0, 1'b0);
            #1;
            if (stall) stall_cnt++;
            if (reg_write_en) en_cnt++;
            if (k == 5) check_eq("t6_err_set", wb_err, 1);
            step();
        end
        check_eq("t6_stall_cycles", stall_cnt, 5);
        check_eq("t6_no_write", en_cnt, 0);
        check_eq("t6_ready", wb_ready, 1);
        mem_busywait = 1'b0;
        drive(1'b1, 0, 1, 1'b1);
        step();
        drive(1'b0, 0, 0, 1'b0);
        check_eq("t6_err_sticky", wb_err, 1);
`else
        check_eq("t6_err_tied", wb_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
